// File: rtl/dphy_pkg.sv
// dphy_pkg: shared types and constants for the D-PHY lane merge slice.
package dphy_pkg;
    localparam int DPHY_WORD_W = 32;
    typedef logic [7:0] byte_t;
    typedef enum logic [1:0] {IDLE, WAIT_ALL, STREAM, FLUSH} lane_state_t;
endpackage

// File: rtl/dphy_skew_fifo.sv
// dphy_skew_fifo: per-lane deskew FIFO, DEPTH x 8, single clock.
// Ports: byte_clk/srst clock and sync reset; clr sync flush; wr/din push;
// rd pop; dout head byte (valid when !empty); empty flag; overflow is high
// while a push targets a full FIFO that is not popping in the same cycle.
module dphy_skew_fifo
    import dphy_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  byte_clk,
    input  logic  srst,
    input  logic  clr,
    input  logic  wr,
    input  logic  rd,
    input  byte_t din,
    output byte_t dout,
    output logic  empty,
    output logic  overflow
);
    localparam int AW = $clog2(DEPTH);
    byte_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic full, do_wr, do_rd;
    assign empty    = cnt == '0;
    assign full     = cnt == (AW+1)'(DEPTH);
    assign overflow = wr && full && !rd;
    assign do_wr    = wr && !overflow;
    assign do_rd    = rd && !empty;
    assign dout     = mem[rp];
    always_ff @(posedge byte_clk)
        if (do_wr) mem[wp] <= din;
    always_ff @(posedge byte_clk)
        if (srst || clr) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
endmodule

// File: rtl/dphy_lane_merge.sv
// dphy_lane_merge: lane deskew and 32-bit word assembly for 1, 2 or 4 lanes.
// Ports: byte_clk_i clock; srst_i sync active-high reset; byte_data_i/valid_i
// aligned per-lane bytes; eop_i end-of-burst pulse; reset_align_o one-cycle
// re-alignment request; data_o/valid_o assembled word (lane 0 in [7:0]).
// Build option: DPHY_PARTIAL_FLUSH_EN emits a zero-padded partial word on eop_i.
module dphy_lane_merge
    import dphy_pkg::*;
#(
    parameter int DATA_LANES    = 2,
    parameter int SKEW_DEPTH    = 4,
    parameter int ALIGN_TIMEOUT = 8
) (
    input  logic                         byte_clk_i,
    input  logic                         srst_i,
    input  logic [DATA_LANES-1:0][7:0]   byte_data_i,
    input  logic [DATA_LANES-1:0]        valid_i,
    input  logic                         eop_i,
    output logic                         reset_align_o,
    output logic [DPHY_WORD_W-1:0]       data_o,
    output logic                         valid_o
);
    localparam int BEATS = 4 / DATA_LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW    = $clog2(ALIGN_TIMEOUT + 1);
    lane_state_t state, state_nxt;
    byte_t [DATA_LANES-1:0] fifo_dout;
    logic [DATA_LANES-1:0] fifo_empty, fifo_ovf;
    logic all_ne, any_ne, wr_en, timeout, abort, flush, clr, pop, last_beat;
    logic [TW-1:0] to_cnt;
    logic [BW-1:0] beat;
    logic [DPHY_WORD_W-1:0] acc;
    logic word_rdy;
    assign all_ne    = ~|fifo_empty;
    assign any_ne    = ~&fifo_empty;
    // Bytes arriving with eop_i or during FLUSH are dropped.
    assign wr_en     = state != FLUSH && !eop_i;
    // to_cnt holds the number of completed WAIT_ALL cycles; this is the last allowed one.
    assign timeout   = state == WAIT_ALL && !all_ne && to_cnt == TW'(ALIGN_TIMEOUT - 1);
    assign abort     = !eop_i && (|fifo_ovf || timeout);
    assign flush     = eop_i || state == FLUSH;
    assign clr       = flush || abort;
    // Lockstep pop; entering STREAM and popping happen in the same cycle.
    assign pop       = all_ne && !clr;
    assign last_beat = beat == BW'(BEATS - 1);
    for (genvar i = 0; i < DATA_LANES; i++) begin : g_lane
        dphy_skew_fifo #(.DEPTH(SKEW_DEPTH)) u_fifo (
            .byte_clk (byte_clk_i),
            .srst     (srst_i),
            .clr      (clr),
            .wr       (valid_i[i] && wr_en),
            .rd       (pop),
            .din      (byte_data_i[i]),
            .dout     (fifo_dout[i]),
            .empty    (fifo_empty[i]),
            .overflow (fifo_ovf[i])
        );
    end
    always_comb begin
        state_nxt = state;
        if (eop_i && state != FLUSH) state_nxt = FLUSH;
        else if (state == FLUSH || abort) state_nxt = IDLE;
        else if (pop) state_nxt = STREAM;
        else if (state == IDLE && any_ne) state_nxt = WAIT_ALL;
    end
    always_ff @(posedge byte_clk_i)
        if (srst_i) begin
            state         <= IDLE;
            to_cnt        <= '0;
            beat          <= '0;
            acc           <= '0;
            word_rdy      <= 1'b0;
            data_o        <= '0;
            valid_o       <= 1'b0;
            reset_align_o <= 1'b0;
        end else begin
            state         <= state_nxt;
            to_cnt        <= (state == WAIT_ALL && state_nxt == WAIT_ALL) ? to_cnt + 1'b1 : '0;
            reset_align_o <= abort;
            valid_o       <= word_rdy;
            if (word_rdy) data_o <= acc;
`ifdef DPHY_PARTIAL_FLUSH_EN
            // A non-zero beat means no complete word is pending, so this never collides with word_rdy.
            if (eop_i && beat != '0) begin
                valid_o <= 1'b1;
                data_o  <= acc;
            end
`endif
            if (clr) begin
                beat     <= '0;
                acc      <= '0;
                word_rdy <= 1'b0;
            end else begin
                word_rdy <= pop && last_beat;
                if (pop) begin
                    beat <= last_beat ? '0 : beat + 1'b1;
                    // Beat 0 starts a fresh word so unfilled upper bytes read as zero.
                    acc  <= (beat == '0 ? '0 : acc) | (DPHY_WORD_W'(fifo_dout) << (32'(beat) * DATA_LANES * 8));
                end
            end
        end
endmodule

// File: tb/tb_dphy_lane_merge.sv
// tb_dphy_lane_merge: directed self-checking bench for 4-, 2- and 1-lane merges.
module tb_dphy_lane_merge;
    import dphy_pkg::*;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    logic [3:0][7:0] d4;
    logic [3:0] v4;
    logic eop4, ra4, vo4;
    logic [31:0] do4;
    logic [1:0][7:0] d2;
    logic [1:0] v2;
    logic eop2, ra2, vo2;
    logic [31:0] do2;
    logic [0:0][7:0] d1;
    logic [0:0] v1;
    logic eop1, ra1, vo1;
    logic [31:0] do1;
    int n_tests = 0, n_fail = 0;
    int n_ra4 = 0, n_ra2 = 0, n_vo4 = 0, n_vo1 = 0;
`ifdef DPHY_PARTIAL_FLUSH_EN
    localparam int PF = 1;
`else
    localparam int PF = 0;
`endif
    dphy_lane_merge #(.DATA_LANES(4), .SKEW_DEPTH(4), .ALIGN_TIMEOUT(8)) u4 (
        .byte_clk_i(clk), .srst_i(rst), .byte_data_i(d4), .valid_i(v4), .eop_i(eop4),
        .reset_align_o(ra4), .data_o(do4), .valid_o(vo4));
    dphy_lane_merge #(.DATA_LANES(2), .SKEW_DEPTH(4), .ALIGN_TIMEOUT(8)) u2 (
        .byte_clk_i(clk), .srst_i(rst), .byte_data_i(d2), .valid_i(v2), .eop_i(eop2),
        .reset_align_o(ra2), .data_o(do2), .valid_o(vo2));
    dphy_lane_merge #(.DATA_LANES(1), .SKEW_DEPTH(4), .ALIGN_TIMEOUT(8)) u1 (
        .byte_clk_i(clk), .srst_i(rst), .byte_data_i(d1), .valid_i(v1), .eop_i(eop1),
        .reset_align_o(ra1), .data_o(do1), .valid_o(vo1));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
        n_ra4 += int'(ra4);
        n_ra2 += int'(ra2);
        n_vo4 += int'(vo4);
        n_vo1 += int'(vo1);
    endtask
    initial begin
        int nw, ek, nra, nvo;
        d4 = '0; v4 = '0; eop4 = 1'b0;
        d2 = '0; v2 = '0; eop2 = 1'b0;
        d1 = '0; v1 = '0; eop1 = 1'b0;
        rst = 1'b1;
        step();
        step();
        check("rst_data", do4, 32'h0);
        check("rst_valid", 32'(vo4), 32'h0);
        check("rst_align", 32'(ra2), 32'h0);
        rst = 1'b0;
        step();
        d4 = {8'h44, 8'h33, 8'h22, 8'h11};
        v4 = 4'hF;
        step();
        v4 = '0;
        check("4l_t0_valid", 32'(vo4), 32'h0);
        step();
        check("4l_t1_valid", 32'(vo4), 32'h0);
        step();
        check("4l_t2_valid", 32'(vo4), 32'h1);
        check("4l_t2_data", do4, 32'h44332211);
        step();
        check("4l_hold_valid", 32'(vo4), 32'h0);
        check("4l_hold_data", do4, 32'h44332211);
        eop4 = 1'b1;
        step();
        eop4 = 1'b0;
        check("4l_eop_novalid", 32'(vo4), 32'h0);
        step();
        nw = 0;
        for (int k = 0; k < 12; k++) begin
            v2 = {k >= 3 && k < 7, k < 4};
            d2 = {8'(8'hB0 + k - 3), 8'(8'hA0 + k)};
            step();
            if (vo2) begin
                if (nw == 0) begin
                    check("skew_w0_data", do2, 32'hB1A1B0A0);
                    check("skew_w0_cycle", k, 6);
                end
                if (nw == 1) begin
                    check("skew_w1_data", do2, 32'hB3A3B2A2);
                    check("skew_w1_cycle", k, 8);
                end
                nw++;
            end
        end
        v2 = '0;
        check("skew_words", nw, 2);
        check("skew_no_realign", n_ra2, 0);
        eop2 = 1'b1;
        step();
        eop2 = 1'b0;
        check("2l_eop_novalid", 32'(vo2), 32'h0);
        step();
        d2 = {8'h00, 8'h55};
        v2 = 2'b01;
        step();
        v2 = '0;
        ek = -1;
        nra = n_ra2;
        for (int k = 1; k < 14; k++) begin
            step();
            if (ra2 && ek < 0) ek = k;
        end
        check("to_pulse_cycle", ek, 9);
        check("to_pulse_count", n_ra2 - nra, 1);
        check("to_state", 32'(u2.state), 32'(IDLE));
        check("to_fifo_empty", 32'(&u2.fifo_empty), 32'h1);
        nvo = n_vo1;
        v1 = 1'b1;
        d1 = 8'h01;
        step();
        d1 = 8'h02;
        step();
        d1 = 8'h03;
        step();
        v1 = 1'b0;
        step();
        check("1l_no_early_valid", n_vo1 - nvo, 0);
        eop1 = 1'b1;
        step();
        eop1 = 1'b0;
        check("1l_partial_valid", 32'(vo1), PF);
`ifdef DPHY_PARTIAL_FLUSH_EN
        check("1l_partial_data", do1, 32'h00030201);
`else
        check("1l_partial_data", do1, 32'h0);
`endif
        step();
        step();
        check("1l_eop_words", n_vo1 - nvo, PF);
        ek = -1;
        for (int k = 0; k < 8; k++) begin
            v1 = k < 4;
            d1 = 8'(8'h10 + k);
            step();
            if (vo1 && ek < 0) begin
                ek = k;
                check("1l_word_data", do1, 32'h13121110);
            end
        end
        check("1l_word_cycle", ek, 5);
        nra = n_ra4;
        nvo = n_vo4;
        ek = -1;
        for (int k = 0; k < 12; k++) begin
            v4 = k < 5 ? 4'b1011 : 4'b0000;
            d4 = {4{8'(8'hC0 + k)}};
            step();
            if (ra4 && ek < 0) ek = k;
        end
        check("ovf_pulse_cycle", ek, 4);
        check("ovf_pulse_count", n_ra4 - nra, 1);
        check("ovf_no_word", n_vo4 - nvo, 0);
        for (int k = 0; k < 4; k++) begin
            v2 = k < 3 ? 2'b11 : 2'b00;
            d2 = {8'(2 * k + 2), 8'(2 * k + 1)};
            step();
        end
        v2 = '0;
        check("rst_pre_valid", 32'(vo2), 32'h1);
        check("rst_pre_data", do2, 32'h04030201);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_valid", 32'(vo2), 32'h0);
        check("rst_mid_data", do2, 32'h0);
        check("rst_mid_data4", do4, 32'h0);
        ek = -1;
        for (int k = 0; k < 6; k++) begin
            v2 = k < 2 ? 2'b11 : 2'b00;
            d2 = {8'(8'h12 + 2 * k), 8'(8'h11 + 2 * k)};
            step();
            if (vo2 && ek < 0) begin
                ek = k;
                check("rst_burst_data", do2, 32'h14131211);
            end
        end
        check("rst_burst_cycle", ek, 3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
